handshake_protocol_assert: RTL and testbench

Parametrised, multi-channel valid/ready protocol monitor: the sequential successor to the team's single-expression combinational assertion checkers. Per channel it checks three rules: valid must hold until accepted, payload must stay stable while stalled, and a stall must not exceed a bounded number of cycles. It captures the first violation, counts violating cycles, and optionally stops simulation. It is instantiated beside bus ports in testbench and eval builds and has no effect on the design it observes.

---
 rtl/hsk_assert_pkg.sv | 27 ++
 rtl/hsk_assert_chan.sv | 83 ++++++++
 rtl/handshake_protocol_assert.sv | 112 +++++++++++
 tb/tb_handshake_protocol_assert.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/hsk_assert_pkg.sv
// Shared types for the valid/ready protocol monitor: rule codes, capture and stall states.
package hsk_assert_pkg;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_DROP    = 2'd1,
    ERR_CHANGE  = 2'd2,
    ERR_TIMEOUT = 2'd3
  } hsk_err_e;

  typedef enum logic {
    ARMED    = 1'b0,
    CAPTURED = 1'b1
  } hsk_cap_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_STALL = 2'd1,
    ST_TIMED = 2'd2
  } hsk_stall_e;

  // $clog2 that never yields a zero-width vector
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hsk_assert_chan.sv
// One monitored channel: history registers, stall counter/FSM and the DROP/CHANGE/TIMEOUT flags.
module hsk_assert_chan
  import hsk_assert_pkg::*;
#(
  parameter int unsigned DW        = 32,
  parameter int unsigned STALL_MAX = 256
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          en,
  input  logic          valid,
  input  logic          ready,
  input  logic [DW-1:0] data,
  output logic          drop,
  output logic          change,
  output logic          timeout
);

  localparam int unsigned    SCW     = clog2_min1(STALL_MAX + 1);
  localparam logic [SCW-1:0] SC_MAX  = SCW'(STALL_MAX);
  localparam logic [SCW-1:0] SC_LAST = SCW'((STALL_MAX > 0) ? STALL_MAX - 1 : 0);
  localparam logic [SCW-1:0] SC_ONE  = SCW'(1);

  logic           pv, pr;
  logic [DW-1:0]  pd;
  logic [SCW-1:0] sc, sc_n;
  hsk_stall_e     st, st_n;
  logic           stalled, stall_now;

  assign stalled   = pv & ~pr;
  assign stall_now = valid & ~ready;

  // History tracks the bus even while checking is disabled
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pv <= 1'b0;
      pr <= 1'b0;
      pd <= '0;
      sc <= '0;
      st <= ST_IDLE;
    end else begin
      pv <= valid;
      pr <= ready;
      pd <= data;
      sc <= sc_n;
      st <= st_n;
    end
  end

  always_comb begin
    st_n = st;
    sc_n = sc;
    if (!en || !stall_now) begin
      st_n = ST_IDLE;
      sc_n = '0;
    end else begin
      case (st)
        ST_IDLE, ST_STALL: begin
          sc_n = sc + SC_ONE;
          st_n = (sc_n == SC_MAX) ? ST_TIMED : ST_STALL;
        end
        ST_TIMED: begin
          st_n = ST_TIMED;
          sc_n = sc;
        end
        default: begin
          st_n = ST_IDLE;
          sc_n = '0;
        end
      endcase
    end
    if (STALL_MAX == 0) begin
      st_n = ST_IDLE;
      sc_n = '0;
    end
  end

  assign drop    = en & stalled & ~valid;
  assign change  = en & stalled & valid & (data != pd);
  // sc sits at SC_MAX after firing, so one fire per stall episode
  assign timeout = en && (STALL_MAX != 0) && stall_now && (sc == SC_LAST);

endmodule

// File: rtl/handshake_protocol_assert.sv
// Multi-channel valid/ready protocol monitor with first-violation capture and saturating count.
// HSK_ASSERT_FATAL_EN: when defined (non-SYNTHESIS), report the capture and $fatal.
module handshake_protocol_assert
  import hsk_assert_pkg::*;
#(
  parameter  int unsigned NCH       = 4,
  parameter  int unsigned DW        = 32,
  parameter  int unsigned STALL_MAX = 256,
  parameter  int unsigned CW        = 16,
  localparam int unsigned CHW       = clog2_min1(NCH)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              en,
  input  logic              clr,
  input  logic [NCH-1:0]    ch_valid,
  input  logic [NCH-1:0]    ch_ready,
  input  logic [NCH*DW-1:0] ch_data,
  output logic              err_any,
  output logic [1:0]        err_code,
  output logic [CHW-1:0]    err_chan,
  output logic [CW-1:0]     err_count
);

  logic [NCH-1:0] drop, change, timeout;
  logic           any_viol, found, capture;
  hsk_err_e       sel_code, code_q, code_n;
  logic [CHW-1:0] sel_chan, chan_q, chan_n;
  logic [CW-1:0]  count_q, count_n;
  hsk_cap_e       state, state_n;

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    hsk_assert_chan #(
      .DW        (DW),
      .STALL_MAX (STALL_MAX)
    ) u_chan (
      .clock   (clock),
      .reset_n (reset_n),
      .en      (en),
      .valid   (ch_valid[i]),
      .ready   (ch_ready[i]),
      .data    (ch_data[i*DW +: DW]),
      .drop    (drop[i]),
      .change  (change[i]),
      .timeout (timeout[i])
    );
  end

  always_comb begin
    found    = 1'b0;
    sel_code = ERR_NONE;
    sel_chan = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (!found && (drop[i] || change[i] || timeout[i])) begin
        found    = 1'b1;
        sel_chan = CHW'(i);
        sel_code = drop[i] ? ERR_DROP : (change[i] ? ERR_CHANGE : ERR_TIMEOUT);
      end
    end
    any_viol = found;
  end

  // clr wipes the capture first so a same-cycle violation re-arms into CAPTURED
  always_comb begin
    state_n = clr ? ARMED    : state;
    count_n = clr ? '0       : count_q;
    code_n  = clr ? ERR_NONE : code_q;
    chan_n  = clr ? '0       : chan_q;
    capture = 1'b0;
    if (any_viol) begin
      if (count_n != '1) count_n = count_n + CW'(1);
      if (state_n == ARMED) begin
        capture = 1'b1;
        state_n = CAPTURED;
        code_n  = sel_code;
        chan_n  = sel_chan;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ARMED;
      count_q <= '0;
      code_q  <= ERR_NONE;
      chan_q  <= '0;
    end else begin
      state   <= state_n;
      count_q <= count_n;
      code_q  <= code_n;
      chan_q  <= chan_n;
    end
  end

  assign err_any   = (state == CAPTURED);
  assign err_code  = code_q;
  assign err_chan  = chan_q;
  assign err_count = count_q;

`ifdef HSK_ASSERT_FATAL_EN
`ifndef SYNTHESIS
  always_ff @(posedge clock) begin
    if (reset_n && capture) begin
      $display("handshake_protocol_assert: violation code=%0d chan=%0d",
               sel_code, sel_chan);
      $fatal(1, "handshake_protocol_assert: protocol violation captured");
    end
  end
`endif
`endif

endmodule

// File: tb/tb_handshake_protocol_assert.sv
// Directed bench for handshake_protocol_assert (NCH=4, DW=8, STALL_MAX=8).
module tb_handshake_protocol_assert;

  localparam int unsigned NCH       = 4;
  localparam int unsigned DW        = 8;
  localparam int unsigned STALL_MAX = 8;
  localparam int unsigned CW        = 16;

  logic              clock = 1'b0;
  logic              reset_n, en, clr;
  logic [NCH-1:0]    ch_valid, ch_ready;
  logic [NCH*DW-1:0] ch_data;
  logic              err_any;
  logic [1:0]        err_code;
  logic [1:0]        err_chan;
  logic [CW-1:0]     err_count;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clock = ~clock;

  handshake_protocol_assert #(
    .NCH       (NCH),
    .DW        (DW),
    .STALL_MAX (STALL_MAX),
    .CW        (CW)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .en        (en),
    .clr       (clr),
    .ch_valid  (ch_valid),
    .ch_ready  (ch_ready),
    .ch_data   (ch_data),
    .err_any   (err_any),
    .err_code  (err_code),
    .err_chan  (err_chan),
    .err_count (err_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic a, input logic [1:0] code,
                           input logic [1:0] chan, input logic [CW-1:0] cnt);
    check({tag, ".err_any"},   32'(err_any),   32'(a));
    check({tag, ".err_code"},  32'(err_code),  32'(code));
    check({tag, ".err_chan"},  32'(err_chan),  32'(chan));
    check({tag, ".err_count"}, 32'(err_count), 32'(cnt));
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset_n  = 1'b0;
    en       = 1'b1;
    clr      = 1'b0;
    ch_valid = '0;
    ch_ready = '0;
    ch_data  = '0;
    #3;
    check_out("reset", 1'b0, 2'd0, 2'd0, 16'd0);
    step();
    step();
    reset_n = 1'b1;

    // Clean full-rate streams on every channel
    for (int k = 0; k < 100; k++) begin
      ch_valid = '1;
      ch_ready = '1;
      ch_data  = $urandom;
      step();
    end
    check_out("stream", 1'b0, 2'd0, 2'd0, 16'd0);

    // Channel 2 stalls for one cycle then drops valid
    ch_valid = 4'b0100;
    ch_ready = 4'b0000;
    step();
    check_out("drop_pre", 1'b0, 2'd0, 2'd0, 16'd0);
    ch_valid = 4'b0000;
    step();
    check_out("drop", 1'b1, 2'd1, 2'd2, 16'd1);
    step();
    check_out("drop_hold", 1'b1, 2'd1, 2'd2, 16'd1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    check_out("clr", 1'b0, 2'd0, 2'd0, 16'd0);

    // Channel 0 CHANGE and channel 1 DROP in the same cycle
    ch_data       = '0;
    ch_data[7:0]  = 8'hA5;
    ch_data[15:8] = 8'h11;
    ch_valid      = 4'b0011;
    ch_ready      = 4'b0000;
    step();
    check_out("chg_pre", 1'b0, 2'd0, 2'd0, 16'd0);
    ch_valid     = 4'b0001;
    ch_data[7:0] = 8'h5A;
    step();
    check_out("chg_drop", 1'b1, 2'd2, 2'd0, 16'd1);
    ch_ready = 4'b0001;
    step();
    check_out("chg_hs", 1'b1, 2'd2, 2'd0, 16'd1);
    ch_valid = 4'b0000;
    ch_ready = 4'b0000;
    clr      = 1'b1;
    step();
    clr = 1'b0;
    check_out("clr2", 1'b0, 2'd0, 2'd0, 16'd0);

    // Channel 3 stalled for 20 cycles: TIMEOUT once on the 8th
    ch_valid       = 4'b1000;
    ch_ready       = 4'b0000;
    ch_data[31:24] = 8'hC3;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k == 7) check_out("to_7", 1'b0, 2'd0, 2'd0, 16'd0);
      if (k == 8) check_out("to_8", 1'b1, 2'd3, 2'd3, 16'd1);
    end
    check_out("to_20", 1'b1, 2'd3, 2'd3, 16'd1);
    ch_ready = 4'b1000;
    step();
    check_out("to_hs", 1'b1, 2'd3, 2'd3, 16'd1);

    // DROP while disabled is ignored; clr with a CHANGE recaptures from scratch
    ch_valid      = 4'b0010;
    ch_ready      = 4'b0000;
    ch_data[15:8] = 8'h33;
    step();
    check_out("dis_pre", 1'b1, 2'd3, 2'd3, 16'd1);
    en       = 1'b0;
    ch_valid = 4'b0000;
    step();
    check_out("dis_drop", 1'b1, 2'd3, 2'd3, 16'd1);
    en       = 1'b1;
    ch_valid = 4'b0010;
    step();
    check_out("en_back", 1'b1, 2'd3, 2'd3, 16'd1);
    clr           = 1'b1;
    ch_data[15:8] = 8'h44;
    step();
    clr = 1'b0;
    check_out("clr_chg", 1'b1, 2'd2, 2'd1, 16'd1);
    step();
    check_out("post_clr", 1'b1, 2'd2, 2'd1, 16'd1);

    // Asynchronous reset mid-stall while CAPTURED
    #3;
    reset_n = 1'b0;
    #1;
    check_out("async_rst", 1'b0, 2'd0, 2'd0, 16'd0);
    ch_valid = 4'b0000;
    step();
    reset_n = 1'b1;
    step();
    check_out("post_rst", 1'b0, 2'd0, 2'd0, 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
